write_full_flags: RTL and testbench



---
 rtl/write_full_flags.sv | 117 +++++++++++
 tb/tb_write_full_flags.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/write_full_flags.sv
// write_full_flags
// Write-domain half of an asynchronous FIFO: binary/Gray write pointer,
// full and programmable almost-full flags, occupancy count, write
// acknowledge and a sticky overflow flag.
//
// Ports
//   wclk          write-domain clock, all state changes on the rising edge
//   wrst          asynchronous active-high reset
//   winc          write request for the current cycle
//   wq2_read_ptr  Gray read pointer, already synchronised into wclk
//   wafull_thresh almost-full threshold in entries, captured by wafull_load
//   wafull_load   one-cycle strobe capturing wafull_thresh
//   wovf_clr      clears the sticky overflow flag
//   waddr         memory write address (combinational from binary pointer)
//   wptr          registered Gray write pointer
//   wfull         registered full flag
//   walmost_full  registered almost-full flag
//   wcount        registered occupancy, 0..DEPTH
//   wack          registered one-cycle pulse for an accepted write
//   woverflow     sticky flag: write attempted while full
module write_full_flags #(
  parameter int unsigned ADDRESS_SIZE = 4,
  parameter int unsigned AFULL_RESET  = (2**ADDRESS_SIZE) - 2
) (
  input  logic                    wclk,
  input  logic                    wrst,
  input  logic                    winc,
  input  logic [ADDRESS_SIZE:0]   wq2_read_ptr,
  input  logic [ADDRESS_SIZE:0]   wafull_thresh,
  input  logic                    wafull_load,
  input  logic                    wovf_clr,
  output logic [ADDRESS_SIZE-1:0] waddr,
  output logic [ADDRESS_SIZE:0]   wptr,
  output logic                    wfull,
  output logic                    walmost_full,
  output logic [ADDRESS_SIZE:0]   wcount,
  output logic                    wack,
  output logic                    woverflow
);

  localparam int unsigned PW = ADDRESS_SIZE + 1;

  logic [ADDRESS_SIZE:0] wbin;
  logic [ADDRESS_SIZE:0] wbinnext;
  logic [ADDRESS_SIZE:0] wgraynext;
  logic [ADDRESS_SIZE:0] rbin;
  logic [ADDRESS_SIZE:0] occ_next;
  logic [ADDRESS_SIZE:0] afull_thresh;
  logic [ADDRESS_SIZE:0] rptr_full_cmp;
  logic                  accept;
  logic                  full_next;
  logic                  almost_next;

  assign waddr = wbin[ADDRESS_SIZE-1:0];

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      rbin[i] = ^(wq2_read_ptr >> i);
    end
  end

  // Full when the next write pointer has lapped the read pointer exactly once:
  // in Gray code that is the read pointer with its two MSBs inverted.
  assign rptr_full_cmp = {~wq2_read_ptr[ADDRESS_SIZE:ADDRESS_SIZE-1],
                          wq2_read_ptr[ADDRESS_SIZE-2:0]};

  always_comb begin
    accept      = winc & ~wfull;
    wbinnext    = wbin + PW'(accept);
    wgraynext   = wbinnext ^ (wbinnext >> 1);
    occ_next    = wbinnext - rbin;
    full_next   = (wgraynext == rptr_full_cmp);
    almost_next = (occ_next >= afull_thresh);
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wcount       <= '0;
      wack         <= 1'b0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      wfull        <= full_next;
      walmost_full <= almost_next;
      wcount       <= occ_next;
      wack         <= accept;
    end
  end

  // The new threshold is used from the edge after the strobe; the strobe
  // edge itself still compares against the old value.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      afull_thresh <= PW'(AFULL_RESET);
    end else if (wafull_load) begin
      afull_thresh <= wafull_thresh;
    end
  end

  // Set has priority over clear when both occur on the same edge.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      woverflow <= 1'b0;
    end else if (winc & wfull) begin
      woverflow <= 1'b1;
    end else if (wovf_clr) begin
      woverflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_write_full_flags.sv
module tb_write_full_flags;

  logic       wclk = 1'b0;
  logic       wrst;
  logic       winc;
  logic [4:0] wq2_read_ptr;
  logic [4:0] wafull_thresh;
  logic       wafull_load;
  logic       wovf_clr;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wcount;
  logic       wack;
  logic       woverflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  write_full_flags #(.ADDRESS_SIZE(4), .AFULL_RESET(14)) dut (
    .wclk          (wclk),
    .wrst          (wrst),
    .winc          (winc),
    .wq2_read_ptr  (wq2_read_ptr),
    .wafull_thresh (wafull_thresh),
    .wafull_load   (wafull_load),
    .wovf_clr      (wovf_clr),
    .waddr         (waddr),
    .wptr          (wptr),
    .wfull         (wfull),
    .walmost_full  (walmost_full),
    .wcount        (wcount),
    .wack          (wack),
    .woverflow     (woverflow)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".waddr"}, 32'(waddr), 0);
    chk({tag, ".wptr"}, 32'(wptr), 0);
    chk({tag, ".wfull"}, 32'(wfull), 0);
    chk({tag, ".walmost_full"}, 32'(walmost_full), 0);
    chk({tag, ".wcount"}, 32'(wcount), 0);
    chk({tag, ".wack"}, 32'(wack), 0);
    chk({tag, ".woverflow"}, 32'(woverflow), 0);
  endtask

  initial begin
    wrst = 1'b1; winc = 1'b0; wq2_read_ptr = 5'b00000;
    wafull_thresh = 5'd0; wafull_load = 1'b0; wovf_clr = 1'b0;
    #3;
    chk_all_zero("reset");
    tick();
    wrst = 1'b0;

    // Fill from empty: 16 accepted writes.
    winc = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("fill%0d.wcount", k), 32'(wcount), 32'(k));
      chk($sformatf("fill%0d.wack", k), 32'(wack), 1);
      chk($sformatf("fill%0d.walmost_full", k), 32'(walmost_full), (k >= 14) ? 1 : 0);
      chk($sformatf("fill%0d.wfull", k), 32'(wfull), (k == 16) ? 1 : 0);
      chk($sformatf("fill%0d.waddr", k), 32'(waddr), 32'(k % 16));
    end
    chk("fill.wptr", 32'(wptr), 32'b11000);

    // Writes while full are rejected and flag overflow.
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("ovf%0d.wack", k), 32'(wack), 0);
      chk($sformatf("ovf%0d.wcount", k), 32'(wcount), 16);
      chk($sformatf("ovf%0d.waddr", k), 32'(waddr), 0);
      chk($sformatf("ovf%0d.wptr", k), 32'(wptr), 32'b11000);
      chk($sformatf("ovf%0d.woverflow", k), 32'(woverflow), 1);
    end

    // Set and clear together: set wins.
    wovf_clr = 1'b1;
    tick();
    chk("ovf_setwins", 32'(woverflow), 1);
    winc = 1'b0;
    tick();
    chk("ovf_clear", 32'(woverflow), 0);
    wovf_clr = 1'b0;

    // Reader consumes one entry.
    wq2_read_ptr = 5'b00001;
    tick();
    chk("rd1.wfull", 32'(wfull), 0);
    chk("rd1.wcount", 32'(wcount), 15);
    chk("rd1.walmost_full", 32'(walmost_full), 1);
    chk("rd1.woverflow", 32'(woverflow), 0);
    winc = 1'b1;
    tick();
    winc = 1'b0;
    chk("wr17.wfull", 32'(wfull), 1);
    chk("wr17.wptr", 32'(wptr), 32'b11001);
    chk("wr17.wcount", 32'(wcount), 16);
    chk("wr17.wack", 32'(wack), 1);
    chk("wr17.waddr", 32'(waddr), 1);
    tick();
    chk("idle.wack", 32'(wack), 0);

    // Programmable threshold: rbin=12 -> occupancy 5.
    wq2_read_ptr = 5'b01010;
    tick();
    chk("occ5.wcount", 32'(wcount), 5);
    chk("occ5.walmost_full", 32'(walmost_full), 0);
    wafull_thresh = 5'd4; wafull_load = 1'b1;
    tick();
    wafull_load = 1'b0;
    chk("thr_strobe.walmost_full", 32'(walmost_full), 0);
    tick();
    chk("thr_after.walmost_full", 32'(walmost_full), 1);
    wq2_read_ptr = 5'b01011;  // rbin=13 -> occupancy 4
    tick();
    chk("occ4.wcount", 32'(wcount), 4);
    chk("occ4.walmost_full", 32'(walmost_full), 1);
    wq2_read_ptr = 5'b01001;  // rbin=14 -> occupancy 3
    tick();
    chk("occ3.wcount", 32'(wcount), 3);
    chk("occ3.walmost_full", 32'(walmost_full), 0);

    // Build wcount=9 with woverflow set, then reset asynchronously.
    wq2_read_ptr = 5'b00001;  // rbin=1 -> full
    tick();
    chk("refull.wfull", 32'(wfull), 1);
    winc = 1'b1;
    tick();
    winc = 1'b0;
    chk("reovf.woverflow", 32'(woverflow), 1);
    wq2_read_ptr = 5'b01100;  // rbin=8 -> occupancy 9
    tick();
    chk("occ9.wcount", 32'(wcount), 9);
    chk("occ9.woverflow", 32'(woverflow), 1);
    chk("occ9.walmost_full", 32'(walmost_full), 1);
    winc = 1'b1;
    #2;
    wrst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    winc = 1'b0;
    wq2_read_ptr = 5'b00000;
    tick();
    chk_all_zero("held_rst");

    // After release the threshold is back to 14.
    wrst = 1'b0;
    winc = 1'b1;
    #1;
    chk("post_rst.waddr0", 32'(waddr), 0);
    tick();
    chk("post_rst.wptr", 32'(wptr), 32'b00001);
    chk("post_rst.wack", 32'(wack), 1);
    chk("post_rst.wcount", 32'(wcount), 1);
    for (int k = 2; k <= 14; k++) begin
      tick();
      chk($sformatf("refill%0d.walmost_full", k), 32'(walmost_full), (k >= 14) ? 1 : 0);
    end
    chk("refill14.wcount", 32'(wcount), 14);
    winc = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
